// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready bus of the InvSubBytes stage: input state, substituted result,
// synchronous abort and activity status.
interface inv_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] packet;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] subbed;
    logic         busy;

    modport slave (
        input  in_valid, packet, clear, out_ready,
        output in_ready, out_valid, subbed, busy
    );

    modport master (
        output in_valid, packet, clear, out_ready,
        input  in_ready, out_valid, subbed, busy
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes BPC bytes of the captured state per
// cycle through BPC shared inverse S-box lookups, byte 0 group first.
module inv_sub_bytes_seq #(
    parameter int unsigned BPC = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    inv_sub_bytes_seq_if.slave bus
);
    localparam int unsigned    NCYC = 16 / BPC;
    localparam int unsigned    CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NCYC - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    if (!((BPC == 1) || (BPC == 2) || (BPC == 4) || (BPC == 8) || (BPC == 16))) begin : g_bad_bpc
        $error("inv_sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  work_q, work_d;

    always_comb begin
        int unsigned k;
        k       = 0;
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        work_d  = bus.packet;
                    end
                end
                BUSY: begin
                    // Byte k lives at bits [(15-k)*8 +: 8]; group cnt covers bytes cnt*BPC..+BPC-1.
                    for (int unsigned g = 0; g < BPC; g++) begin
                        k = 32'(cnt_q) * BPC + g;
                        work_d[(15 - k) * 8 +: 8] = inv_sbox(work_q[(15 - k) * 8 +: 8]);
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY) || (state_q == DONE);
    assign bus.subbed    = work_q;
endmodule
